// File: rtl/rst_seq_pkg.sv
// Shared types and elaboration helpers for the staged reset sequencer.
// Holds the FSM state encoding and the counter-width helpers.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    STABLE,
    RELEASE,
    RUN
  } state_t;

  localparam int         MAX_STAGES = 8;
  localparam logic [7:0] LOSS_MAX   = 8'hFF;

  // Width of a counter that must reach limit-1; never narrower than one bit.
  function automatic int cnt_width(input int limit);
    return (limit <= 1) ? 1 : $clog2(limit);
  endfunction

  function automatic bit stages_legal(input int num_stages);
    return (num_stages >= 1) && (num_stages <= MAX_STAGES);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Board button synchroniser and debouncer; pressed_out is the debounced,
// polarity-normalised button state (1 = pressed).
module btn_debounce
  import rst_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic clock_in,
  input  logic rst_in,
  input  logic btn_in,
  output logic pressed_out
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          level;
  logic          sync_a;
  logic          sync_b;
  logic [CW-1:0] cnt;

  assign level = BTN_ACTIVE_LOW ? ~btn_in : btn_in;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge value of its source (essential for the sync chain).
  always_ff @(posedge clock_in) begin
    if (rst_in) begin
      sync_a      <= 1'b0;
      sync_b      <= 1'b0;
      cnt         <= '0;
      pressed_out <= 1'b0;
    end else begin
      sync_a <= level;
      sync_b <= sync_a;
      if (sync_b == pressed_out) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        pressed_out <= sync_b;
        cnt         <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release after PLL lock; every stage re-asserts at once on
// lock loss or a debounced button press, then the sequence re-runs.
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int STABLE_CYCLES   = 1024,
  parameter int STAGE_GAP       = 16,
  parameter int NUM_STAGES      = 3,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clock_in,
  input  logic                  rst_in,
  input  logic                  locked_in,
  input  logic                  btn_rst_in,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  ready_out,
  output logic [7:0]            lock_loss_cnt_out
);

  if (!stages_legal(NUM_STAGES)) begin : g_bad_stages
    $error("reset_sequencer: NUM_STAGES must be in 1..8");
  end

  localparam int             SCW        = cnt_width(STABLE_CYCLES);
  localparam int             GCW        = cnt_width(STAGE_GAP);
  localparam int             STW        = cnt_width(NUM_STAGES);
  localparam logic [SCW-1:0] STABLE_END = SCW'(STABLE_CYCLES - 1);
  localparam logic [GCW-1:0] GAP_END    = GCW'(STAGE_GAP - 1);
  localparam logic [STW-1:0] LAST_STAGE = STW'(NUM_STAGES - 1);

  state_t                state, state_next;
  logic [SCW-1:0]        cnt, cnt_next;
  logic [GCW-1:0]        gap, gap_next;
  logic [STW-1:0]        stage, stage_next;
  logic [NUM_STAGES-1:0] rst_next;
  logic                  ready_next;
  logic [7:0]            loss_next;
  logic                  btn_pressed;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
  ) u_btn_debounce (
    .clock_in   (clock_in),
    .rst_in     (rst_in),
    .btn_in     (btn_rst_in),
    .pressed_out(btn_pressed)
  );

  always_ff @(posedge clock_in) begin
    if (rst_in) begin
      state             <= WAIT_LOCK;
      cnt               <= '0;
      gap               <= '0;
      stage             <= '0;
      rst_out           <= '1;
      ready_out         <= 1'b0;
      lock_loss_cnt_out <= '0;
    end else begin
      state             <= state_next;
      cnt               <= cnt_next;
      gap               <= gap_next;
      stage             <= stage_next;
      rst_out           <= rst_next;
      ready_out         <= ready_next;
      lock_loss_cnt_out <= loss_next;
    end
  end

  // NOTE: every signal gets a hold default first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    gap_next   = gap;
    stage_next = stage;
    rst_next   = rst_out;
    ready_next = ready_out;
    loss_next  = lock_loss_cnt_out;

    unique case (state)
      WAIT_LOCK: begin
        rst_next   = '1;
        ready_next = 1'b0;
        if (locked_in && !btn_pressed) begin
          state_next = STABLE;
          cnt_next   = '0;
        end
      end
      STABLE: begin
        cnt_next = cnt + SCW'(1);
        if (cnt == STABLE_END) begin
          rst_next[0] = 1'b0;
          if (NUM_STAGES == 1) begin
            ready_next = 1'b1;
            state_next = RUN;
          end else begin
            state_next = RELEASE;
            stage_next = STW'(1);
            gap_next   = '0;
          end
        end
      end
      RELEASE: begin
        gap_next = gap + GCW'(1);
        if (gap == GAP_END) begin
          for (int i = 0; i < NUM_STAGES; i++) begin
            if (STW'(i) == stage) rst_next[i] = 1'b0;
          end
          gap_next   = '0;
          stage_next = stage + STW'(1);
          if (stage == LAST_STAGE) begin
            ready_next = 1'b1;
            state_next = RUN;
          end
        end
      end
      RUN: ;
      default: state_next = WAIT_LOCK;
    endcase

    // Abort outranks every in-state transition above.
    if (state != WAIT_LOCK && (!locked_in || btn_pressed)) begin
      state_next = WAIT_LOCK;
      rst_next   = '1;
      ready_next = 1'b0;
      if (!locked_in && lock_loss_cnt_out != LOSS_MAX)
        loss_next = lock_loss_cnt_out + 8'd1;
    end
  end

endmodule
